// File: rtl/tetris_field_engine.sv
// Tetris playfield engine: holds the stored field, moves one falling piece
// under gravity and horizontal strobes, locks it, then clears full rows one
// scanned row per cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for new_game after reset
// SPAWN    | piece_ready high, waiting for a piece to be offered
// FALL     | active piece moves on tick / left_i / right_i
// LOCK     | piece ORed into the stored field
// CLEAR    | scan rows bottom-up, removing full rows
// GAMEOVER | spawn position was blocked; field frozen until new_game
module tetris_field_engine #(
    parameter int COLS      = 10,
    parameter int ROWS      = 20,
    parameter int SPAWN_COL = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   new_game,
    input  logic                   tick,
    input  logic                   left_i,
    input  logic                   right_i,
    input  logic                   piece_valid,
    input  logic [15:0]            piece_shape,
    output logic                   piece_ready,
    output logic [ROWS*COLS-1:0]   display_array,
    output logic [15:0]            lines_cleared,
    output logic                   gameover
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    typedef logic [ROWS-1:0][COLS-1:0] field_t;
    typedef enum logic [2:0] {IDLE, SPAWN, FALL, LOCK, CLEAR, GAMEOVER} state_t;

    state_t            state_q, state_d;
    field_t            field_q, field_d;
    field_t            active;
    logic [15:0]       shape_q, shape_d;
    logic signed [5:0] x_q, x_d;
    logic [5:0]        y_q, y_d;
    logic [RW-1:0]     scan_q, scan_d;
    logic [15:0]       lines_q, lines_d;

    // True if any set mask cell falls outside the field or on a stored cell.
    function automatic logic collides(input logic [15:0] shp, input int px,
                                      input int py, input field_t fld);
        logic hit;
        hit = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (shp[4'(r * 4 + c)]) begin
                    if ((py + r) >= ROWS || (px + c) < 0 || (px + c) >= COLS)
                        hit = 1'b1;
                    else if (fld[RW'(py + r)][CW'(px + c)])
                        hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    // Field-shaped image of the piece; cells outside the field are dropped.
    function automatic field_t piece_cells(input logic [15:0] shp, input int px,
                                           input int py);
        field_t f;
        f = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (shp[4'(r * 4 + c)] && (py + r) < ROWS &&
                    (px + c) >= 0 && (px + c) < COLS)
                    f[RW'(py + r)][CW'(px + c)] = 1'b1;
            end
        end
        return f;
    endfunction

    // Active piece rendered at its current position.
    always_comb begin
        active = piece_cells(shape_q, int'(x_q), int'(y_q));
    end

    // Next-state, datapath updates and Moore outputs.
    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        shape_d     = shape_q;
        x_d         = x_q;
        y_d         = y_q;
        scan_d      = scan_q;
        lines_d     = lines_q;
        piece_ready = 1'b0;
        gameover    = 1'b0;

        case (state_q)
            IDLE: begin
                if (new_game) begin
                    field_d = '0;
                    lines_d = '0;
                    state_d = SPAWN;
                end
            end
            SPAWN: begin
                piece_ready = 1'b1;
                if (piece_valid) begin
                    shape_d = piece_shape;
                    x_d     = 6'(SPAWN_COL);
                    y_d     = '0;
                    state_d = collides(piece_shape, SPAWN_COL, 0, field_q) ? GAMEOVER : FALL;
                end
            end
            FALL: begin
                // tick wins over moves; simultaneous left+right cancel out
                if (tick) begin
                    if (!collides(shape_q, int'(x_q), int'(y_q) + 1, field_q))
                        y_d = y_q + 6'd1;
                    else
                        state_d = LOCK;
                end else if (left_i && !right_i) begin
                    if (!collides(shape_q, int'(x_q) - 1, int'(y_q), field_q))
                        x_d = x_q - 6'sd1;
                end else if (right_i && !left_i) begin
                    if (!collides(shape_q, int'(x_q) + 1, int'(y_q), field_q))
                        x_d = x_q + 6'sd1;
                end
            end
            LOCK: begin
                field_d = field_q | active;
                scan_d  = RW'(ROWS - 1);
                state_d = CLEAR;
            end
            CLEAR: begin
                if (&field_q[scan_q]) begin
                    // drop everything above the full row; stay on it to rescan
                    for (int i = 1; i < ROWS; i++) begin
                        if (RW'(i) <= scan_q)
                            field_d[RW'(i)] = field_q[RW'(i - 1)];
                    end
                    field_d[0] = '0;
                    if (lines_q != 16'hFFFF)
                        lines_d = lines_q + 16'd1;
                end else if (scan_q == '0) begin
                    state_d = SPAWN;
                end else begin
                    scan_d = scan_q - RW'(1);
                end
            end
            GAMEOVER: begin
                gameover = 1'b1;
                if (new_game) begin
                    field_d = '0;
                    lines_d = '0;
                    state_d = SPAWN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            field_q <= '0;
            shape_q <= '0;
            x_q     <= 6'(SPAWN_COL);
            y_q     <= '0;
            scan_q  <= '0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            shape_q <= shape_d;
            x_q     <= x_d;
            y_q     <= y_d;
            scan_q  <= scan_d;
            lines_q <= lines_d;
        end
    end

    // Piece overlay is only shown while it is falling.
    always_comb begin
        display_array = (state_q == FALL) ? (field_q | active) : field_q;
        lines_cleared = lines_q;
    end

endmodule

// File: tb/tb_tetris_field_engine.sv
// Self-checking bench for tetris_field_engine with a cell-array reference model.
module tb_tetris_field_engine;

    localparam int COLS      = 10;
    localparam int ROWS      = 20;
    localparam int SPAWN_COL = 3;
    localparam int NB        = ROWS * COLS;

    localparam int P_IDLE  = 0;
    localparam int P_SPAWN = 1;
    localparam int P_FALL  = 2;
    localparam int P_OVER  = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          new_game = 1'b0;
    logic          tick = 1'b0;
    logic          left_i = 1'b0;
    logic          right_i = 1'b0;
    logic          piece_valid = 1'b0;
    logic [15:0]   piece_shape = '0;
    logic          piece_ready;
    logic [NB-1:0] display_array;
    logic [15:0]   lines_cleared;
    logic          gameover;

    int total = 0;
    int bad   = 0;

    int          mfld [ROWS][COLS];
    logic [15:0] mshape;
    int          mx, my, mlines, mphase;

    tetris_field_engine #(.COLS(COLS), .ROWS(ROWS), .SPAWN_COL(SPAWN_COL)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .new_game      (new_game),
        .tick          (tick),
        .left_i        (left_i),
        .right_i       (right_i),
        .piece_valid   (piece_valid),
        .piece_shape   (piece_shape),
        .piece_ready   (piece_ready),
        .display_array (display_array),
        .lines_cleared (lines_cleared),
        .gameover      (gameover)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_hit(input logic [15:0] s, input int x, input int y);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (s[r * 4 + c]) begin
                    if (y + r >= ROWS || x + c < 0 || x + c >= COLS) return 1'b1;
                    if (mfld[y + r][x + c] != 0) return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic logic [NB-1:0] m_disp(input bit with_piece);
        logic [NB-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (mfld[r][c] != 0) v[r * COLS + c] = 1'b1;
        if (with_piece)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (mshape[r * 4 + c] && my + r < ROWS && mx + c >= 0 && mx + c < COLS)
                        v[(my + r) * COLS + mx + c] = 1'b1;
        return v;
    endfunction

    task automatic m_clear_field();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mfld[r][c] = 0;
    endtask

    // Merge the piece, then remove every full row at once (gravity compaction).
    task automatic m_lock(output int k);
        int out [ROWS][COLS];
        int w;
        bit full;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mshape[r * 4 + c]) mfld[my + r][mx + c] = 1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                out[r][c] = 0;
        w = ROWS - 1;
        k = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < COLS; c++)
                if (mfld[r][c] == 0) full = 1'b0;
            if (full) k++;
            else begin
                for (int c = 0; c < COLS; c++) out[w][c] = mfld[r][c];
                w--;
            end
        end
        mfld = out;
        mlines = (mlines + k > 65535) ? 65535 : mlines + k;
    endtask

    task automatic m_fall(input bit t, input bit l, input bit r, output bit locked);
        locked = 1'b0;
        if (t) begin
            if (!m_hit(mshape, mx, my + 1)) my++;
            else locked = 1'b1;
        end else if (l && !r) begin
            if (!m_hit(mshape, mx - 1, my)) mx--;
        end else if (r && !l) begin
            if (!m_hit(mshape, mx + 1, my)) mx++;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        clk1();
        new_game = 1'b0;
        m_clear_field();
        mlines = 0;
        mphase = P_SPAWN;
    endtask

    task automatic fresh();
        reset_n = 1'b0;
        clk1();
        reset_n = 1'b1;
        clk1();
        mphase = P_IDLE;
        pulse_new_game();
    endtask

    task automatic offer(input logic [15:0] shp);
        total++;
        if (piece_ready !== 1'b1) begin
            bad++;
            $display("FAIL spawn_ready: piece_ready got %b want 1", piece_ready);
        end
        piece_valid = 1'b1;
        piece_shape = shp;
        clk1();
        piece_valid = 1'b0;
        mshape = shp;
        if (m_hit(shp, SPAWN_COL, 0)) begin
            mphase = P_OVER;
            total++;
            if (gameover !== 1'b1) begin
                bad++;
                $display("FAIL spawn_gameover: gameover got %b want 1", gameover);
            end
        end else begin
            mx = SPAWN_COL;
            my = 0;
            mphase = P_FALL;
        end
        total++;
        if (display_array !== m_disp(mphase == P_FALL)) begin
            bad++;
            $display("FAIL spawn_display: got %h want %h", display_array, m_disp(mphase == P_FALL));
        end
    endtask

    task automatic step_fall(input bit t, input bit l, input bit r, input bit ng,
                             input string name, output bit locked);
        tick = t; left_i = l; right_i = r; new_game = ng;
        clk1();
        tick = 1'b0; left_i = 1'b0; right_i = 1'b0; new_game = 1'b0;
        m_fall(t, l, r, locked);
        total++;
        if (display_array !== m_disp(!locked)) begin
            bad++;
            $display("FAIL %s: display got %h want %h", name, display_array, m_disp(!locked));
        end
    endtask

    // Called with the DUT in LOCK; checks the clear scan length and result.
    task automatic finish_lock();
        int k;
        clk1();
        m_lock(k);
        repeat (ROWS + k - 1) clk1();
        total++;
        if (piece_ready !== 1'b0) begin
            bad++;
            $display("FAIL clear_len_early: piece_ready got %b want 0 (k=%0d)", piece_ready, k);
        end
        clk1();
        mphase = P_SPAWN;
        total++;
        if (piece_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_len: piece_ready got %b want 1 (k=%0d)", piece_ready, k);
        end
        total++;
        if (display_array !== m_disp(1'b0)) begin
            bad++;
            $display("FAIL clear_field: got %h want %h", display_array, m_disp(1'b0));
        end
        total++;
        if (lines_cleared !== 16'(mlines)) begin
            bad++;
            $display("FAIL clear_lines: got %0d want %0d", lines_cleared, mlines);
        end
    endtask

    task automatic drop(input logic [15:0] shp, input int dx);
        bit locked;
        offer(shp);
        if (mphase != P_FALL) return;
        for (int i = 0; i < (dx < 0 ? -dx : dx); i++)
            step_fall(1'b0, dx < 0, dx > 0, 1'b0, "drop_move", locked);
        locked = 1'b0;
        for (int i = 0; i < ROWS + 4 && !locked; i++)
            step_fall(1'b1, 1'b0, 1'b0, 1'b0, "drop_tick", locked);
        if (!locked) begin
            total++;
            bad++;
            $display("FAIL drop_timeout: no lock after %0d ticks", ROWS + 4);
            return;
        end
        finish_lock();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        clk1();
        clk1();
        total++;
        if ({piece_ready, gameover, lines_cleared} !== 18'd0 || display_array !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b over=%b lines=%0d disp=%h want all 0",
                     piece_ready, gameover, lines_cleared, display_array);
        end
        reset_n = 1'b1;
        tick = 1'b1; left_i = 1'b1; piece_valid = 1'b1; piece_shape = 16'h0033;
        clk1();
        clk1();
        tick = 1'b0; left_i = 1'b0; piece_valid = 1'b0;
        mphase = P_IDLE;
        total++;
        if (piece_ready !== 1'b0 || display_array !== '0) begin
            bad++;
            $display("FAIL idle_hold: ready=%b disp=%h want 0", piece_ready, display_array);
        end
        pulse_new_game();
        total++;
        if (piece_ready !== 1'b1) begin
            bad++;
            $display("FAIL new_game_spawn: piece_ready got %b want 1", piece_ready);
        end
    endtask

    task automatic test_o_drop();
        logic [NB-1:0] exp;
        drop(16'h0033, 0);
        exp = '0;
        exp[18 * COLS + 3] = 1'b1;
        exp[18 * COLS + 4] = 1'b1;
        exp[19 * COLS + 3] = 1'b1;
        exp[19 * COLS + 4] = 1'b1;
        total++;
        if (display_array !== exp || lines_cleared !== 16'd0) begin
            bad++;
            $display("FAIL o_drop: disp=%h lines=%0d want %h lines=0", display_array, lines_cleared, exp);
        end
    endtask

    task automatic test_moves();
        bit locked;
        offer(16'h1111);
        for (int i = 0; i < 3; i++)
            step_fall(1'b0, 1'b1, 1'b0, 1'b0, "move_left", locked);
        total++;
        if (display_array[0] !== 1'b1 || display_array[3] !== 1'b0) begin
            bad++;
            $display("FAIL left_to_col0: col0=%b col3=%b want 1/0", display_array[0], display_array[3]);
        end
        step_fall(1'b0, 1'b1, 1'b0, 1'b0, "left_at_wall", locked);
        step_fall(1'b0, 1'b1, 1'b1, 1'b0, "left_right_same", locked);
        step_fall(1'b0, 1'b0, 1'b1, 1'b1, "right_with_new_game", locked);
        step_fall(1'b1, 1'b1, 1'b0, 1'b0, "tick_and_left", locked);
        step_fall(1'b1, 1'b0, 1'b1, 1'b0, "tick_and_right", locked);
        locked = 1'b0;
        for (int i = 0; i < ROWS + 4 && !locked; i++)
            step_fall(1'b1, 1'b0, 1'b0, 1'b0, "moves_tick", locked);
        if (locked) finish_lock();
        else begin
            total++; bad++;
            $display("FAIL moves_timeout: no lock");
        end
    endtask

    task automatic test_line_clear();
        fresh();
        drop(16'h000F, -3);
        new_game = 1'b1;
        clk1();
        new_game = 1'b0;
        total++;
        if (piece_ready !== 1'b1 || display_array !== m_disp(1'b0)) begin
            bad++;
            $display("FAIL new_game_in_spawn: ready=%b disp=%h want 1 %h", piece_ready, display_array, m_disp(1'b0));
        end
        drop(16'h000F, 1);
        drop(16'h1111, 5);
        drop(16'h1111, 6);
        total++;
        if (lines_cleared !== 16'd1) begin
            bad++;
            $display("FAIL single_clear: lines got %0d want 1", lines_cleared);
        end
    endtask

    task automatic test_four_clear();
        fresh();
        for (int c = 0; c < 9; c++) drop(16'h1111, c - SPAWN_COL);
        drop(16'h1111, 6);
        total++;
        if (lines_cleared !== 16'd4 || display_array !== '0) begin
            bad++;
            $display("FAIL four_clear: lines=%0d disp=%h want 4 and empty", lines_cleared, display_array);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit locked;
        drop(16'h0033, 0);
        offer(16'h1111);
        locked = 1'b0;
        for (int i = 0; i < ROWS + 4 && !locked; i++)
            step_fall(1'b1, 1'b0, 1'b0, 1'b0, "pre_reset_tick", locked);
        clk1();
        repeat (3) clk1();
        reset_n = 1'b0;
        #2;
        total++;
        if ({piece_ready, gameover, lines_cleared} !== 18'd0 || display_array !== '0) begin
            bad++;
            $display("FAIL reset_mid_clear: ready=%b over=%b lines=%0d disp=%h want all 0",
                     piece_ready, gameover, lines_cleared, display_array);
        end
        clk1();
        reset_n = 1'b1;
        m_clear_field();
        mlines = 0;
        mphase = P_IDLE;
        for (int i = 0; i < 6; i++) begin
            tick = i[0]; left_i = i[1]; right_i = ~i[0]; piece_valid = 1'b1; piece_shape = 16'h0033;
            clk1();
            total++;
            if (piece_ready !== 1'b0 || display_array !== '0) begin
                bad++;
                $display("FAIL post_reset_idle: ready=%b disp=%h want 0", piece_ready, display_array);
            end
        end
        tick = 1'b0; left_i = 1'b0; right_i = 1'b0; piece_valid = 1'b0;
        pulse_new_game();
        total++;
        if (piece_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_new_game: piece_ready got %b want 1", piece_ready);
        end
    endtask

    task automatic test_gameover();
        fresh();
        for (int i = 0; i < ROWS / 2; i++) drop(16'h0033, 0);
        offer(16'h0033);
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1; left_i = i[0]; piece_valid = 1'b1;
            clk1();
            total++;
            if (gameover !== 1'b1 || piece_ready !== 1'b0 || display_array !== m_disp(1'b0)) begin
                bad++;
                $display("FAIL gameover_hold: over=%b ready=%b disp=%h want 1 0 %h",
                         gameover, piece_ready, display_array, m_disp(1'b0));
            end
        end
        tick = 1'b0; left_i = 1'b0; piece_valid = 1'b0;
        pulse_new_game();
        total++;
        if (gameover !== 1'b0 || piece_ready !== 1'b1 || display_array !== '0 || lines_cleared !== 16'd0) begin
            bad++;
            $display("FAIL gameover_restart: over=%b ready=%b disp=%h lines=%0d",
                     gameover, piece_ready, display_array, lines_cleared);
        end
    endtask

    task automatic test_random();
        logic [15:0] shapes [10];
        bit locked;
        int rnd;
        shapes = '{16'h0033, 16'h000F, 16'h1111, 16'h0027, 16'h0036,
                   16'h0063, 16'h0117, 16'h2222, 16'h8888, 16'h0330};
        for (int d = 0; d < 40; d++) begin
            if (mphase == P_OVER) pulse_new_game();
            repeat ($urandom_range(0, 2)) clk1();
            offer(shapes[$urandom_range(0, 9)]);
            if (mphase != P_FALL) continue;
            locked = 1'b0;
            for (int i = 0; i < 400 && !locked; i++) begin
                rnd = $urandom_range(0, 7);
                step_fall(rnd == 0 || rnd == 1 || rnd == 6, rnd == 2 || rnd == 4 || rnd == 6,
                          rnd == 3 || rnd == 4, rnd == 7, "rand_step", locked);
            end
            if (locked) finish_lock();
            else begin
                total++; bad++;
                $display("FAIL rand_timeout: drop %0d never locked", d);
                return;
            end
        end
    endtask

    initial begin
        mphase = P_IDLE;
        mlines = 0;
        mx = SPAWN_COL;
        my = 0;
        mshape = '0;
        m_clear_field();
        test_reset();
        test_o_drop();
        test_moves();
        test_line_clear();
        test_four_clear();
        test_reset_mid_clear();
        test_gameover();
        fresh();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
